// File: rtl/spi_slave_fifo.sv
// Oversampled SPI slave with first-word-fall-through TX/RX FIFOs, used as a loopback
// partner for spi_top. Length, bit order and sample/drive edges are latched per character.

module spi_slave_fifo_buf #(
    parameter int W     = 64,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] push_data,
    input  logic         push_valid,
    output logic         push_ready,
    output logic [W-1:0] pop_data,
    output logic         pop_valid,
    input  logic         pop_ready
);
    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         full;
    logic         empty;
    logic         do_push;
    logic         do_pop;

    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push_ready = ~full;
    assign pop_valid  = ~empty;
    // Head reads as zero when empty so the reset value of rx_data is clean.
    assign pop_data   = empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign do_push    = push_valid & ~full;
    assign do_pop     = pop_ready & ~empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end
endmodule

// state  | meaning
// IDLE   | ss high, waiting for a synchronised ss falling edge
// LOAD   | pop TX head (or zeros), latch cfg, drive first miso bit
// SHIFT  | sample mosi / drive miso on the selected sclk edges
// PUSH   | write the received word to the RX FIFO, then next character or idle
module spi_slave_fifo #(
    parameter int MAX_LEN    = 64,
    parameter int LEN_W      = 6,
    parameter int FIFO_DEPTH = 4,
    parameter int FIFO_AW    = 2
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               ss_pad_i,
    input  logic               sclk_pad_i,
    input  logic               mosi_pad_i,
    output logic               miso_pad_o,
    output logic               miso_oe_o,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_lsb,
    input  logic               cfg_rx_negedge,
    input  logic               cfg_tx_negedge,
    input  logic [MAX_LEN-1:0] tx_data,
    input  logic               tx_valid,
    output logic               tx_ready,
    output logic [MAX_LEN-1:0] rx_data,
    output logic               rx_valid,
    input  logic               rx_ready,
    output logic               tx_underrun,
    output logic               rx_overrun,
    output logic               busy
);
    localparam int CNT_W = LEN_W + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT, ST_PUSH} state_t;

    state_t             state;
    logic               ss_meta;
    logic               ss_sync;
    logic               ss_prev;
    logic               sclk_meta;
    logic               sclk_sync;
    logic               sclk_prev;
    logic               mosi_meta;
    logic               mosi_sync;
    logic [LEN_W-1:0]   len_m1_q;
    logic               lsb_q;
    logic               rx_neg_q;
    logic               tx_neg_q;
    logic [CNT_W-1:0]   bit_cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic [CNT_W-1:0]   len_full;
    logic [LEN_W-1:0]   cfg_len_m1;
    logic [MAX_LEN-1:0] shift_tx;
    logic [MAX_LEN-1:0] shift_rx;
    logic [MAX_LEN-1:0] tx_head;
    logic               tx_avail;
    logic               tx_pop;
    logic               rx_push;
    logic               rx_space;
    logic               sclk_rise;
    logic               sclk_fall;
    logic               sample_edge;
    logic               drive_edge;
    logic               char_done;
    logic               sample_now;
    logic               drive_now;
    logic               ss_fall;

    // Transmit-order bit k of a word whose last valid index is 'last'.
    function automatic logic pick_bit(input logic [MAX_LEN-1:0] word,
                                      input logic [LEN_W-1:0]   last,
                                      input logic               lsb,
                                      input logic [LEN_W-1:0]   k);
        logic [LEN_W-1:0] idx;
        idx = lsb ? k : last - k;
        return word[idx];
    endfunction

    // Storing len-1 makes cfg_len==0 wrap naturally to MAX_LEN-1.
    assign cfg_len_m1  = cfg_len - 1'b1;
    assign len_full    = {1'b0, len_m1_q} + 1'b1;
    assign sclk_rise   = sclk_sync & ~sclk_prev;
    assign sclk_fall   = ~sclk_sync & sclk_prev;
    assign ss_fall     = ss_prev & ~ss_sync;
    assign sample_edge = rx_neg_q ? sclk_fall : sclk_rise;
    assign drive_edge  = tx_neg_q ? sclk_fall : sclk_rise;
    assign char_done   = (bit_cnt == len_full);
    assign sample_now  = (state == ST_SHIFT) && !char_done && !ss_sync && sample_edge;
    assign cnt_next    = bit_cnt + {{LEN_W{1'b0}}, sample_now};
    assign drive_now   = (state == ST_SHIFT) && !char_done && !ss_sync && drive_edge &&
                         (cnt_next != '0) && (cnt_next < len_full);
    assign tx_pop      = (state == ST_LOAD) && !ss_sync;
    assign rx_push     = (state == ST_PUSH);
    assign miso_oe_o   = ~ss_sync;
    assign busy        = (state != ST_IDLE);

    spi_slave_fifo_buf #(.W(MAX_LEN), .DEPTH(FIFO_DEPTH), .AW(FIFO_AW)) u_tx_fifo (
        .clk        (wb_clk_i),
        .rst        (wb_rst_i),
        .push_data  (tx_data),
        .push_valid (tx_valid),
        .push_ready (tx_ready),
        .pop_data   (tx_head),
        .pop_valid  (tx_avail),
        .pop_ready  (tx_pop)
    );

    spi_slave_fifo_buf #(.W(MAX_LEN), .DEPTH(FIFO_DEPTH), .AW(FIFO_AW)) u_rx_fifo (
        .clk        (wb_clk_i),
        .rst        (wb_rst_i),
        .push_data  (shift_rx),
        .push_valid (rx_push),
        .push_ready (rx_space),
        .pop_data   (rx_data),
        .pop_valid  (rx_valid),
        .pop_ready  (rx_ready)
    );

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ss_meta     <= 1'b1;
            ss_sync     <= 1'b1;
            ss_prev     <= 1'b1;
            sclk_meta   <= 1'b0;
            sclk_sync   <= 1'b0;
            sclk_prev   <= 1'b0;
            mosi_meta   <= 1'b0;
            mosi_sync   <= 1'b0;
            state       <= ST_IDLE;
            len_m1_q    <= '0;
            lsb_q       <= 1'b0;
            rx_neg_q    <= 1'b0;
            tx_neg_q    <= 1'b0;
            bit_cnt     <= '0;
            shift_tx    <= '0;
            shift_rx    <= '0;
            miso_pad_o  <= 1'b0;
            tx_underrun <= 1'b0;
            rx_overrun  <= 1'b0;
        end else begin
            ss_meta     <= ss_pad_i;
            ss_sync     <= ss_meta;
            ss_prev     <= ss_sync;
            sclk_meta   <= sclk_pad_i;
            sclk_sync   <= sclk_meta;
            sclk_prev   <= sclk_sync;
            mosi_meta   <= mosi_pad_i;
            mosi_sync   <= mosi_meta;
            tx_underrun <= 1'b0;
            rx_overrun  <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (ss_fall) state <= ST_LOAD;
                end
                ST_LOAD: begin
                    if (ss_sync) begin
                        state <= ST_IDLE;
                    end else begin
                        len_m1_q    <= cfg_len_m1;
                        lsb_q       <= cfg_lsb;
                        rx_neg_q    <= cfg_rx_negedge;
                        tx_neg_q    <= cfg_tx_negedge;
                        shift_tx    <= tx_head;
                        shift_rx    <= '0;
                        bit_cnt     <= '0;
                        miso_pad_o  <= pick_bit(tx_head, cfg_len_m1, cfg_lsb, '0);
                        tx_underrun <= ~tx_avail;
                        state       <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // A completed character is kept even if ss rises right after it.
                    if (char_done) begin
                        state <= ST_PUSH;
                    end else if (ss_sync) begin
                        state <= ST_IDLE;
                    end else begin
                        if (sample_now) begin
                            bit_cnt <= cnt_next;
                            if (lsb_q) shift_rx[bit_cnt[LEN_W-1:0]] <= mosi_sync;
                            else       shift_rx <= {shift_rx[MAX_LEN-2:0], mosi_sync};
                        end
                        if (drive_now)
                            miso_pad_o <= pick_bit(shift_tx, len_m1_q, lsb_q, cnt_next[LEN_W-1:0]);
                    end
                end
                ST_PUSH: begin
                    rx_overrun <= ~rx_space;
                    state      <= ss_sync ? ST_IDLE : ST_LOAD;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_slave_fifo.sv
// Bench for spi_slave_fifo: a bit-level SPI master plus a queue model of both FIFOs.
module tb_spi_slave_fifo;
    localparam int MAX_LEN = 64;
    localparam int LEN_W   = 6;
    localparam int DEPTH   = 4;

    logic               wb_clk_i = 1'b0;
    logic               wb_rst_i;
    logic               ss_pad_i;
    logic               sclk_pad_i;
    logic               mosi_pad_i;
    logic               miso_pad_o;
    logic               miso_oe_o;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_lsb;
    logic               cfg_rx_negedge;
    logic               cfg_tx_negedge;
    logic [MAX_LEN-1:0] tx_data;
    logic               tx_valid;
    logic               tx_ready;
    logic [MAX_LEN-1:0] rx_data;
    logic               rx_valid;
    logic               rx_ready;
    logic               tx_underrun;
    logic               rx_overrun;
    logic               busy;

    spi_slave_fifo #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .FIFO_DEPTH(DEPTH), .FIFO_AW(2)) dut (
        .wb_clk_i       (wb_clk_i),
        .wb_rst_i       (wb_rst_i),
        .ss_pad_i       (ss_pad_i),
        .sclk_pad_i     (sclk_pad_i),
        .mosi_pad_i     (mosi_pad_i),
        .miso_pad_o     (miso_pad_o),
        .miso_oe_o      (miso_oe_o),
        .cfg_len        (cfg_len),
        .cfg_lsb        (cfg_lsb),
        .cfg_rx_negedge (cfg_rx_negedge),
        .cfg_tx_negedge (cfg_tx_negedge),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .tx_underrun    (tx_underrun),
        .rx_overrun     (rx_overrun),
        .busy           (busy)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int checks = 0;
    int errors = 0;
    int under_cnt = 0;
    int over_cnt = 0;

    logic [63:0] tx_q[$];
    logic [63:0] rx_q[$];
    logic [63:0] mo_q[$];

    always @(negedge wb_clk_i) begin
        if (tx_underrun === 1'b1) under_cnt++;
        if (rx_overrun === 1'b1) over_cnt++;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge wb_clk_i);
        #1;
    endtask

    function automatic logic [63:0] len_mask(input int len_eff);
        logic [63:0] m;
        m = '1;
        if (len_eff < 64) m = (64'd1 << len_eff) - 64'd1;
        return m;
    endfunction

    task automatic push_tx(input logic [63:0] w);
        checks++;
        if (tx_ready !== 1'(tx_q.size() < DEPTH)) begin
            errors++;
            $display("FAIL push tx_ready got %0b exp %0b", tx_ready, tx_q.size() < DEPTH);
        end
        tx_data  = w;
        tx_valid = 1'b1;
        wait_clk(1);
        tx_valid = 1'b0;
        if (tx_q.size() < DEPTH) tx_q.push_back(w);
    endtask

    // Slave samples on sample edge k and must already present miso bit k there.
    task automatic master_bits(input int nbits, input int len_eff, input bit lsb, input bit rxn,
                               input bit last, input logic [63:0] mo, output logic [63:0] mi);
        int pos;
        mi = '0;
        for (int k = 0; k < nbits; k++) begin
            pos = lsb ? k : len_eff - 1 - k;
            mosi_pad_i = mo[pos];
            wait_clk(4);
            if (!rxn) mi[pos] = miso_pad_o;
            sclk_pad_i = 1'b1;
            if (last && k == nbits - 1 && !rxn) begin
                wait_clk(1);
                ss_pad_i = 1'b1;
                wait_clk(4);
                sclk_pad_i = 1'b0;
                wait_clk(4);
            end else begin
                wait_clk(8);
                if (rxn) mi[pos] = miso_pad_o;
                sclk_pad_i = 1'b0;
                if (last && k == nbits - 1) begin
                    wait_clk(1);
                    ss_pad_i = 1'b1;
                end
                wait_clk(4);
            end
        end
    endtask

    task automatic run_burst(input int nchar, input int len, input bit lsb, input bit rxn,
                             input bit txn, input string tag);
        int          len_eff;
        int          u0;
        int          o0;
        int          eu;
        int          eo;
        logic [63:0] mask;
        logic [63:0] exp_tx;
        logic [63:0] mo;
        logic [63:0] mi;
        cfg_len        = 6'(len);
        cfg_lsb        = lsb;
        cfg_rx_negedge = rxn;
        cfg_tx_negedge = txn;
        len_eff = (len == 0) ? 64 : len;
        mask = len_mask(len_eff);
        u0 = under_cnt;
        o0 = over_cnt;
        eu = 0;
        eo = 0;
        ss_pad_i = 1'b0;
        wait_clk(8);
        for (int c = 0; c < nchar; c++) begin
            if (tx_q.size() > 0) exp_tx = tx_q.pop_front() & mask;
            else begin
                exp_tx = '0;
                eu++;
            end
            if (c == 0) begin
                checks++;
                if (tx_ready !== 1'(tx_q.size() < DEPTH)) begin
                    errors++;
                    $display("FAIL %s tx_ready after load got %0b exp %0b", tag, tx_ready, tx_q.size() < DEPTH);
                end
                checks++;
                if (busy !== 1'b1 || miso_oe_o !== 1'b1) begin
                    errors++;
                    $display("FAIL %s busy/oe in char got %0b/%0b exp 1/1", tag, busy, miso_oe_o);
                end
            end
            mo = (mo_q.size() > 0) ? mo_q.pop_front() : {$urandom, $urandom};
            master_bits(len_eff, len_eff, lsb, rxn, c == nchar - 1, mo, mi);
            checks++;
            if (mi !== exp_tx) begin
                errors++;
                $display("FAIL %s miso char %0d got %h exp %h", tag, c, mi, exp_tx);
            end
            if (rx_q.size() < DEPTH) rx_q.push_back(mo & mask);
            else eo++;
        end
        wait_clk(8);
        checks++;
        if (under_cnt - u0 !== eu) begin
            errors++;
            $display("FAIL %s tx_underrun pulses got %0d exp %0d", tag, under_cnt - u0, eu);
        end
        checks++;
        if (over_cnt - o0 !== eo) begin
            errors++;
            $display("FAIL %s rx_overrun pulses got %0d exp %0d", tag, over_cnt - o0, eo);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy after burst got %0b exp 0", tag, busy);
        end
    endtask

    task automatic drain_rx(input string tag);
        logic [63:0] exp_rx;
        while (rx_q.size() > 0) begin
            exp_rx = rx_q.pop_front();
            checks++;
            if (rx_valid !== 1'b1 || rx_data !== exp_rx) begin
                errors++;
                $display("FAIL %s rx word got v=%0b %h exp v=1 %h", tag, rx_valid, rx_data, exp_rx);
            end
            rx_ready = 1'b1;
            wait_clk(1);
            rx_ready = 1'b0;
        end
        checks++;
        if (rx_valid !== 1'b0 || rx_data !== '0) begin
            errors++;
            $display("FAIL %s rx empty got v=%0b %h exp v=0 0", tag, rx_valid, rx_data);
        end
    endtask

    task automatic test_reset();
        wb_rst_i       = 1'b1;
        ss_pad_i       = 1'b1;
        sclk_pad_i     = 1'b0;
        mosi_pad_i     = 1'b0;
        cfg_len        = '0;
        cfg_lsb        = 1'b0;
        cfg_rx_negedge = 1'b0;
        cfg_tx_negedge = 1'b0;
        tx_data        = '0;
        tx_valid       = 1'b0;
        rx_ready       = 1'b0;
        wait_clk(3);
        wb_rst_i = 1'b0;
        wait_clk(4);
        checks++;
        if ({miso_pad_o, miso_oe_o, tx_ready, rx_valid, tx_underrun, rx_overrun, busy} !== 7'b0010000) begin
            errors++;
            $display("FAIL reset outputs got miso=%0b oe=%0b txr=%0b rxv=%0b und=%0b ovr=%0b busy=%0b",
                     miso_pad_o, miso_oe_o, tx_ready, rx_valid, tx_underrun, rx_overrun, busy);
        end
        checks++;
        if (rx_data !== '0) begin
            errors++;
            $display("FAIL reset rx_data got %h exp 0", rx_data);
        end
    endtask

    task automatic test_msb_rxneg();
        push_tx(64'h5a);
        mo_q.push_back(64'ha5);
        run_burst(1, 8, 1'b0, 1'b1, 1'b0, "len8_msb");
        drain_rx("len8_msb");
    endtask

    task automatic test_lsb_txneg();
        push_tx(64'ha55a);
        mo_q.push_back(64'h5aa5);
        run_burst(1, 16, 1'b1, 1'b0, 1'b1, "len16_lsb");
        drain_rx("len16_lsb");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < DEPTH; i++) push_tx({$urandom, $urandom});
        checks++;
        if (tx_ready !== 1'b0) begin
            errors++;
            $display("FAIL full tx_ready got %0b exp 0", tx_ready);
        end
        run_burst(4, 0, 1'b0, 1'b0, 1'b1, "len64_burst");
        drain_rx("len64_burst");
    endtask

    task automatic test_underrun_overrun();
        run_burst(1, 8, 1'b0, 1'b0, 1'b1, "underrun");
        drain_rx("underrun");
        run_burst(5, 8, 1'b1, 1'b1, 1'b1, "overrun");
        drain_rx("overrun");
    endtask

    task automatic test_abort();
        logic [63:0] mi;
        push_tx(64'hc3);
        push_tx(64'h96);
        cfg_len        = 6'd8;
        cfg_lsb        = 1'b0;
        cfg_rx_negedge = 1'b0;
        cfg_tx_negedge = 1'b1;
        ss_pad_i = 1'b0;
        wait_clk(8);
        void'(tx_q.pop_front());
        master_bits(5, 8, 1'b0, 1'b0, 1'b0, 64'h3c, mi);
        ss_pad_i = 1'b1;
        wait_clk(3);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL abort busy 3 cycles after ss rise got %0b exp 0", busy);
        end
        wait_clk(8);
        checks++;
        if (rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort rx_valid got %0b exp 0", rx_valid);
        end
        run_burst(1, 8, 1'b0, 1'b0, 1'b1, "after_abort");
        drain_rx("after_abort");
    endtask

    task automatic test_reset_mid_char();
        logic [63:0] mi;
        for (int i = 0; i < DEPTH; i++) push_tx({$urandom, $urandom});
        run_burst(2, 8, 1'b0, 1'b1, 1'b0, "prefill");
        ss_pad_i = 1'b0;
        wait_clk(8);
        void'(tx_q.pop_front());
        master_bits(3, 8, 1'b0, 1'b1, 1'b0, 64'h55, mi);
        push_tx(64'h1234);
        wb_rst_i = 1'b1;
        #1;
        tx_q.delete();
        rx_q.delete();
        checks++;
        if ({miso_pad_o, miso_oe_o, tx_ready, rx_valid, tx_underrun, rx_overrun, busy} !== 7'b0010000) begin
            errors++;
            $display("FAIL midreset outputs got miso=%0b oe=%0b txr=%0b rxv=%0b und=%0b ovr=%0b busy=%0b",
                     miso_pad_o, miso_oe_o, tx_ready, rx_valid, tx_underrun, rx_overrun, busy);
        end
        checks++;
        if (rx_data !== '0) begin
            errors++;
            $display("FAIL midreset rx_data got %h exp 0", rx_data);
        end
        wait_clk(2);
        ss_pad_i = 1'b1;
        wait_clk(2);
        wb_rst_i = 1'b0;
        wait_clk(4);
        run_burst(1, 8, 1'b0, 1'b1, 1'b0, "post_reset");
        drain_rx("post_reset");
    endtask

    task automatic test_random();
        int ntx;
        for (int it = 0; it < 8; it++) begin
            ntx = $urandom_range(0, 3);
            for (int i = 0; i < ntx; i++) push_tx({$urandom, $urandom});
            run_burst($urandom_range(1, 3), $urandom_range(0, 24), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "random");
            drain_rx("random");
        end
    endtask

    initial begin
        test_reset();
        test_msb_rxneg();
        test_lsb_txneg();
        test_back_to_back();
        test_underrun_overrun();
        test_abort();
        test_reset_mid_char();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
